// File: rtl/interrupt_vector_fetch.sv
// Fetch-side interrupt responder: reads the ISR address from the IVT as two 16-bit
// words (high first) while stalling fetch, then redirects the PC with a one-cycle load.
module interrupt_vector_fetch #(
  parameter logic [31:0] IVT_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt_raised,
  input  logic [31:0] current_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic        fetch_stall,
  output logic        pc_load,
  output logic [31:0] pc_load_value,
  output logic [31:0] saved_pc,
  output logic        busy,
  output logic        vector_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_HI = 2'd1,
    ST_RD_LO = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  localparam logic [7:0]  WAIT_LAST   = 8'(MAX_WAIT - 1);
  localparam logic [31:0] IVT_LO_ADDR = IVT_BASE + 32'd1;

  state_t      r_state;
  logic        r_pending;
  logic [7:0]  r_wait;
  logic [15:0] r_hi_word;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic        r_fetch_stall;
  logic        r_pc_load;
  logic [31:0] r_pc_load_value;
  logic [31:0] r_saved_pc;
  logic        r_busy;
  logic        r_vector_error;

  // Sequencer state, wait counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_pending       <= 1'b0;
      r_wait          <= 8'd0;
      r_hi_word       <= 16'd0;
      r_imem_req      <= 1'b0;
      r_imem_addr     <= 32'd0;
      r_fetch_stall   <= 1'b0;
      r_pc_load       <= 1'b0;
      r_pc_load_value <= 32'd0;
      r_saved_pc      <= 32'd0;
      r_busy          <= 1'b0;
      r_vector_error  <= 1'b0;
    end else begin
      r_pc_load      <= 1'b0;
      r_vector_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (interrupt_raised || r_pending) begin
            r_state       <= ST_RD_HI;
            r_saved_pc    <= current_pc;
            r_pending     <= 1'b0;
            r_wait        <= 8'd0;
            r_imem_req    <= 1'b1;
            r_imem_addr   <= IVT_BASE;
            r_fetch_stall <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        ST_RD_HI: begin
          r_pending <= r_pending | interrupt_raised;
          if (imem_valid) begin
            r_hi_word   <= imem_rdata;
            r_wait      <= 8'd0;
            r_state     <= ST_RD_LO;
            r_imem_addr <= IVT_LO_ADDR;
          end else if (r_wait == WAIT_LAST) begin
            r_state        <= ST_IDLE;
            r_wait         <= 8'd0;
            r_vector_error <= 1'b1;
            r_imem_req     <= 1'b0;
            r_fetch_stall  <= 1'b0;
            r_busy         <= 1'b0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_RD_LO: begin
          r_pending <= r_pending | interrupt_raised;
          if (imem_valid) begin
            r_state         <= ST_LOAD;
            r_wait          <= 8'd0;
            r_imem_req      <= 1'b0;
            r_pc_load       <= 1'b1;
            r_pc_load_value <= {r_hi_word, imem_rdata};
          end else if (r_wait == WAIT_LAST) begin
            r_state        <= ST_IDLE;
            r_wait         <= 8'd0;
            r_vector_error <= 1'b1;
            r_imem_req     <= 1'b0;
            r_fetch_stall  <= 1'b0;
            r_busy         <= 1'b0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_LOAD: begin
          // A pulse here is served after one IDLE cycle, via pending
          r_pending     <= r_pending | interrupt_raised;
          r_state       <= ST_IDLE;
          r_fetch_stall <= 1'b0;
          r_busy        <= 1'b0;
        end
        default: begin
          r_state       <= ST_IDLE;
          r_wait        <= 8'd0;
          r_imem_req    <= 1'b0;
          r_fetch_stall <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = r_imem_req;
  assign imem_addr     = r_imem_addr;
  assign fetch_stall   = r_fetch_stall;
  assign pc_load       = r_pc_load;
  assign pc_load_value = r_pc_load_value;
  assign saved_pc      = r_saved_pc;
  assign busy          = r_busy;
  assign vector_error  = r_vector_error;

endmodule

// File: tb/tb_interrupt_vector_fetch.sv
// Randomized bench for interrupt_vector_fetch: each service's cycle timeline is derived
// from its read delays by plain arithmetic and compared cycle by cycle.
module tb_interrupt_vector_fetch;

  localparam logic [31:0] TB_BASE     = 32'hFFFF_FFFF;
  localparam int          TB_MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        interrupt_raised;
  logic [31:0] current_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        fetch_stall;
  logic        pc_load;
  logic [31:0] pc_load_value;
  logic [31:0] saved_pc;
  logic        busy;
  logic        vector_error;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_load_value;
  logic [31:0] exp_saved_pc;
  logic [31:0] lo_addr;

  interrupt_vector_fetch #(
    .IVT_BASE (TB_BASE),
    .MAX_WAIT (TB_MAX_WAIT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .interrupt_raised (interrupt_raised),
    .current_pc       (current_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .imem_valid       (imem_valid),
    .fetch_stall      (fetch_stall),
    .pc_load          (pc_load),
    .pc_load_value    (pc_load_value),
    .saved_pc         (saved_pc),
    .busy             (busy),
    .vector_error     (vector_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic e_req, input logic [31:0] e_addr, input logic e_stall,
                               input logic e_pc_load, input logic e_verr);
    check_eq("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) check_eq("imem_addr", imem_addr, e_addr);
    check_eq("fetch_stall", 32'(fetch_stall), 32'(e_stall));
    check_eq("busy", 32'(busy), 32'(e_stall));
    check_eq("pc_load", 32'(pc_load), 32'(e_pc_load));
    check_eq("pc_load_value", pc_load_value, exp_load_value);
    check_eq("vector_error", 32'(vector_error), 32'(e_verr));
    check_eq("saved_pc", saved_pc, exp_saved_pc);
  endtask

  // One cycle with no interrupt; memory strobes are noise that must be ignored
  task automatic idle_cycle();
    interrupt_raised = 1'b0;
    current_pc       = $urandom;
    imem_valid       = 1'($urandom_range(0, 1));
    imem_rdata       = 16'($urandom);
    @(posedge clk); #1;
    check_outputs(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // dh/dl: wait cycles before imem_valid on each read (>= MAX_WAIT means never)
  // irq_mode: 0 none while busy, 1 random pulses, 2 pulses in first two RD_LO cycles
  task automatic run_service(input int dh, input int dl, input logic [15:0] hi, input logic [15:0] lo,
                             input logic [31:0] pc, input logic pend_in, input int irq_mode,
                             output logic pend_out);
    logic to_hi, to_lo;
    int   th, tl, last;
    to_hi = (dh >= TB_MAX_WAIT);
    to_lo = !to_hi && (dl >= TB_MAX_WAIT);
    th    = to_hi ? TB_MAX_WAIT : dh + 1;
    tl    = to_hi ? 0 : (to_lo ? TB_MAX_WAIT : dl + 1);
    last  = (to_hi || to_lo) ? th + tl : th + tl + 1;
    pend_out = 1'b0;

    current_pc       = pc;
    interrupt_raised = pend_in ? 1'($urandom_range(0, 1)) : 1'b1;
    imem_valid       = 1'($urandom_range(0, 1));
    imem_rdata       = 16'($urandom);
    exp_saved_pc     = pc;

    for (int k = 1; k <= last + 1; k++) begin
      @(posedge clk); #1;
      if (k <= th) begin
        check_outputs(1'b1, TB_BASE, 1'b1, 1'b0, 1'b0);
      end else if (k <= th + tl) begin
        check_outputs(1'b1, lo_addr, 1'b1, 1'b0, 1'b0);
      end else if (k <= last) begin
        exp_load_value = {hi, lo};
        check_outputs(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      end else begin
        check_outputs(1'b0, 32'd0, 1'b0, 1'b0, to_hi || to_lo);
      end

      if (k <= last) begin
        current_pc = $urandom;
        imem_rdata = 16'($urandom);
        if (k <= th) begin
          imem_valid = !to_hi && (k == dh + 1);
          if (imem_valid) imem_rdata = hi;
        end else if (k <= th + tl) begin
          imem_valid = !to_lo && (k - th == dl + 1);
          if (imem_valid) imem_rdata = lo;
        end else begin
          imem_valid = 1'($urandom_range(0, 1));
        end
        case (irq_mode)
          1:       interrupt_raised = ($urandom_range(0, 3) == 0);
          2:       interrupt_raised = (k == th + 1) || (k == th + 2);
          default: interrupt_raised = 1'b0;
        endcase
        if (interrupt_raised) pend_out = 1'b1;
      end
    end
  endtask

  task automatic reset_mid_op();
    current_pc       = 32'h1234_5678;
    interrupt_raised = 1'b1;
    imem_valid       = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_seq busy", 32'(busy), 32'd1);
    interrupt_raised = 1'b0;
    imem_valid       = 1'b1;
    imem_rdata       = 16'hABCD;
    @(posedge clk); #1;
    check_eq("rst_seq rd_lo addr", imem_addr, lo_addr);
    interrupt_raised = 1'b1;
    imem_valid       = 1'b0;
    @(posedge clk); #1;
    interrupt_raised = 1'b0;
    imem_valid       = 1'b1;
    imem_rdata       = 16'h1111;
    rst              = 1'b1;
    @(posedge clk); #1;
    exp_load_value = 32'd0;
    exp_saved_pc   = 32'd0;
    check_outputs(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_seq imem_addr", imem_addr, 32'd0);
    rst = 1'b0;
    repeat (8) idle_cycle();
  endtask

  initial begin
    logic pend;
    int   dh, dl, mode;
    lo_addr          = TB_BASE + 32'd1;
    rst              = 1'b1;
    interrupt_raised = 1'b0;
    current_pc       = 32'd0;
    imem_valid       = 1'b0;
    imem_rdata       = 16'd0;
    exp_load_value   = 32'd0;
    exp_saved_pc     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    check_eq("reset imem_addr", imem_addr, 32'd0);
    check_eq("wrapped lo address", lo_addr, 32'h0000_0000);
    rst = 1'b0;

    run_service(0, 0, 16'h0000, 16'h0120, 32'h0000_0040, 1'b0, 0, pend);
    check_eq("zero-wait saved_pc", saved_pc, 32'h0000_0040);
    idle_cycle();
    run_service(2, 2, 16'h0001, 16'h8000, $urandom, 1'b0, 0, pend);
    idle_cycle();
    run_service(TB_MAX_WAIT, 0, 16'h5555, 16'hAAAA, $urandom, 1'b0, 0, pend);
    idle_cycle();
    run_service(1, TB_MAX_WAIT, 16'h1357, 16'h2468, $urandom, 1'b0, 0, pend);
    run_service(0, 2, 16'hDEAD, 16'hBEEF, $urandom, 1'b0, 2, pend);
    run_service(1, 0, 16'hCAFE, 16'hF00D, $urandom, pend, 0, pend);
    idle_cycle();
    reset_mid_op();

    pend = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (!pend) repeat ($urandom_range(0, 2)) idle_cycle();
      dh   = $urandom_range(0, 5);
      dl   = $urandom_range(0, 5);
      mode = $urandom_range(0, 1);
      run_service(dh, dl, 16'($urandom), 16'($urandom), $urandom, pend, mode, pend);
    end
    if (pend) begin
      run_service(0, 0, 16'h0BAD, 16'hF00D, $urandom, pend, 0, pend);
    end
    repeat (3) idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
